// File: rtl/spi_rx.sv
// SPI mode-0 receive path: samples sdi LSB first on each bit_en strobe, assembles
// a word of up to DATA_LEN bits and queues it in a first-word-fall-through FIFO.
module spi_rx #(
  parameter int DLY        = 1,
  parameter int DATA_LEN   = 32,
  parameter int DATA_VLD   = $clog2(DATA_LEN),
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          rx_req_i,
  input  logic [DATA_VLD-1:0]           rx_len_i,
  output logic                          rx_req_rdy_o,
  input  logic                          bit_en,
  output logic                          clk_en,
  input  logic                          sdi,
  output logic [DATA_LEN-1:0]           rx_data_o,
  output logic                          rx_vld_o,
  input  logic                          rx_rdy_i,
  output logic                          rx_eot,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RECV = 3'b010,
    DONE = 3'b100
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_VLD-1:0]   len_q, len_d;
  logic [DATA_VLD-1:0]   cnt_q, cnt_d;
  logic [DATA_LEN-1:0]   shift_q, shift_d;

  logic [DATA_LEN-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_LEN-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [AW:0]           level_q, level_d;

  logic full, empty, push, pop;

  // Register timing is modelled with zero delay; the parameter stays for interface compatibility.
  logic unused_dly;
  assign unused_dly = (DLY != 0);

  assign full         = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty        = (level_q == '0);
  assign push         = (state_q == DONE);
  assign pop          = !empty && rx_rdy_i;
  assign rx_req_rdy_o = (state_q == IDLE) && !full;
  assign rx_vld_o     = !empty;
  assign rx_data_o    = mem_q[rptr_q];
  assign rx_level_o   = level_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    clk_en  = 1'b0;
    rx_eot  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_req_i && rx_req_rdy_o) begin
          len_d   = rx_len_i;
          cnt_d   = '0;
          shift_d = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        clk_en = 1'b1;
        if (bit_en) begin
          shift_d[cnt_q] = sdi;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == len_q) state_d = DONE;
        end
      end
      DONE: begin
        rx_eot  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Acceptance is gated on !full, so a push always finds a free slot.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      mem_d[wptr_q] = shift_q;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: tb/tb_spi_rx.sv
// Randomized bench for spi_rx: a queue of expected words is fed from each request's
// length and serial data, and checked against the FIFO as it drains.
module tb_spi_rx;
  localparam int DL = 32;
  localparam int DV = 5;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          rx_req_i = 1'b0;
  logic [DV-1:0] rx_len_i = '0;
  logic          rx_req_rdy_o;
  logic          bit_en = 1'b0;
  logic          clk_en;
  logic          sdi = 1'b0;
  logic [DL-1:0] rx_data_o;
  logic          rx_vld_o;
  logic          rx_rdy_i = 1'b0;
  logic          rx_eot;
  logic [4:0]    rx_level_o;

  spi_rx dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_req_i(rx_req_i), .rx_len_i(rx_len_i),
    .rx_req_rdy_o(rx_req_rdy_o), .bit_en(bit_en), .clk_en(clk_en), .sdi(sdi),
    .rx_data_o(rx_data_o), .rx_vld_o(rx_vld_o), .rx_rdy_i(rx_rdy_i),
    .rx_eot(rx_eot), .rx_level_o(rx_level_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_chk = 0;
  int            n_fail = 0;
  int            en_cnt = 0;
  int            eot_cnt = 0;
  bit            rand_rdy = 1'b0;
  logic [DL-1:0] cur_exp = '0;
  logic [DL-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard sampled on the falling edge, where all inputs are stable.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      exp_q.delete();
    end else begin
      chk("level", 64'(rx_level_o), 64'(exp_q.size()));
      chk("vld", 64'(rx_vld_o), 64'(exp_q.size() != 0));
      if (rx_vld_o && rx_rdy_i && exp_q.size() != 0) begin
        chk("data", 64'(rx_data_o), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (clk_en) en_cnt++;
      if (rx_eot) begin
        eot_cnt++;
        exp_q.push_back(cur_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_rdy) rx_rdy_i = 1'($urandom_range(0, 1));
  endtask

  // One request: gap<0 gives random gaps before every strobe, otherwise a fixed
  // gap between strobes with the first strobe right after acceptance.
  task automatic word(input int len, input logic [31:0] data, input int gap,
                      input bit pop_done, output int waits);
    int g;
    logic [31:0] mask;
    waits    = 0;
    rx_len_i = len[DV-1:0];
    rx_req_i = 1'b1;
    while (!rx_req_rdy_o && waits < 300) begin
      tick();
      waits++;
    end
    if (!rx_req_rdy_o) begin
      chk("req_timeout", 64'(waits), 64'd0);
      rx_req_i = 1'b0;
      return;
    end
    mask    = (len == 31) ? 32'hFFFF_FFFF : ((32'd1 << (len + 1)) - 32'd1);
    cur_exp = data & mask;
    tick();
    rx_req_i = 1'b0;
    for (int i = 0; i <= len; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? 0 : gap);
      repeat (g) begin
        sdi = 1'($urandom_range(0, 1));
        chk("clk_en_gap", 64'(clk_en), 64'd1);
        chk("eot_recv", 64'(rx_eot), 64'd0);
        tick();
      end
      bit_en = 1'b1;
      sdi    = data[i];
      chk("clk_en_bit", 64'(clk_en), 64'd1);
      tick();
      bit_en = 1'b0;
    end
    chk("eot", 64'(rx_eot), 64'd1);
    chk("clk_en_done", 64'(clk_en), 64'd0);
    if (pop_done) rx_rdy_i = 1'b1;
    tick();
    if (pop_done) rx_rdy_i = 1'b0;
    chk("eot_end", 64'(rx_eot), 64'd0);
  endtask

  initial begin
    int w;
    logic [31:0] rd;
    repeat (3) tick();
    rst_n_i = 1'b1;
    tick();

    // idle: bit_en strobes must not start anything
    chk("rst_rdy", 64'(rx_req_rdy_o), 64'd1);
    chk("rst_clk_en", 64'(clk_en), 64'd0);
    chk("rst_data", 64'(rx_data_o), 64'd0);
    bit_en = 1'b1; sdi = 1'b1;
    repeat (3) tick();
    bit_en = 1'b0;
    chk("idle_clk_en", 64'(clk_en), 64'd0);
    chk("idle_vld", 64'(rx_vld_o), 64'd0);
    chk("idle_rdy", 64'(rx_req_rdy_o), 64'd1);

    // 8-bit word, strobes 4 cycles apart
    en_cnt = 0; eot_cnt = 0;
    word(7, 32'hA5, 3, 1'b0, w);
    chk("a5_clk_en_cycles", 64'(en_cnt), 64'd29);
    chk("a5_eot_cnt", 64'(eot_cnt), 64'd1);
    chk("a5_vld", 64'(rx_vld_o), 64'd1);
    chk("a5_data", 64'(rx_data_o), 64'h0000_00A5);
    rx_rdy_i = 1'b1; tick(); rx_rdy_i = 1'b0;
    chk("a5_level", 64'(rx_level_o), 64'd0);

    // full-width word, bit_en every cycle
    en_cnt = 0;
    word(31, 32'hDEAD_BEEF, 0, 1'b0, w);
    chk("de_clk_en_cycles", 64'(en_cnt), 64'd32);
    chk("de_data", 64'(rx_data_o), 64'hDEAD_BEEF);
    rx_rdy_i = 1'b1; tick(); rx_rdy_i = 1'b0;

    // fill the FIFO with 1-bit words, then block the 17th request
    for (int k = 0; k < 16; k++) word(0, (k % 2 == 0) ? 32'd1 : 32'd0, 0, 1'b0, w);
    chk("full_level", 64'(rx_level_o), 64'd16);
    chk("full_rdy", 64'(rx_req_rdy_o), 64'd0);
    rx_req_i = 1'b1; rx_len_i = '0;
    repeat (3) tick();
    chk("full_no_accept", 64'(clk_en), 64'd0);
    rx_rdy_i = 1'b1;
    tick();
    chk("after_pop_rdy", 64'(rx_req_rdy_o), 64'd1);
    word(0, 32'd1, 0, 1'b0, w);
    chk("held_accept_wait", 64'(w), 64'd0);
    repeat (20) tick();
    rx_rdy_i = 1'b0;

    // pop coincident with the DONE push at level 3
    for (int k = 0; k < 3; k++) word(int'($urandom_range(0, 31)), $urandom, -1, 1'b0, w);
    chk("pp_level_pre", 64'(rx_level_o), 64'd3);
    word(7, $urandom, 0, 1'b1, w);
    chk("pp_level_post", 64'(rx_level_o), 64'd3);
    rx_rdy_i = 1'b1; repeat (6) tick(); rx_rdy_i = 1'b0;

    // reset in the middle of a 16-bit word, with a word already queued
    word(3, 32'h9, 0, 1'b0, w);
    rx_len_i = 5'd15; rx_req_i = 1'b1;
    tick();
    rx_req_i = 1'b0;
    rd = 32'hFFFF;
    for (int i = 0; i < 5; i++) begin
      bit_en = 1'b1; sdi = rd[i]; tick();
    end
    bit_en = 1'b0;
    chk("mid_clk_en", 64'(clk_en), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_rdy", 64'(rx_req_rdy_o), 64'd1);
    chk("arst_clk_en", 64'(clk_en), 64'd0);
    chk("arst_vld", 64'(rx_vld_o), 64'd0);
    chk("arst_level", 64'(rx_level_o), 64'd0);
    chk("arst_data", 64'(rx_data_o), 64'd0);
    chk("arst_eot", 64'(rx_eot), 64'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();
    word(15, 32'h1234, -1, 1'b0, w);
    chk("post_rst_data", 64'(rx_data_o), 64'h0000_1234);

    // random traffic with random back-pressure
    rand_rdy = 1'b1;
    repeat (40) word(int'($urandom_range(0, 31)), $urandom, -1, 1'b0, w);
    rand_rdy = 1'b0;
    rx_rdy_i = 1'b1;
    repeat (20) tick();
    chk("drain_level", 64'(rx_level_o), 64'd0);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
